// File: rtl/elevator_pkg.sv
// Shared definitions for the elevator call path: default sizes, width helpers
// and the floor-index type also used by the elevator controller.
package elevator_pkg;

   localparam int NUM_FLOORS_DEFAULT      = 2;
   localparam int DEBOUNCE_CYCLES_DEFAULT = 4;

   // Floor feedback is never narrower than one bit, even for tiny buildings.
   function automatic int floor_w(input int num_floors);
      return (num_floors <= 2) ? 1 : $clog2(num_floors);
   endfunction

   function automatic int debounce_cnt_w(input int debounce_cycles);
      return (debounce_cycles <= 2) ? 1 : $clog2(debounce_cycles);
   endfunction

   localparam int FLOOR_W_DEFAULT = floor_w(NUM_FLOORS_DEFAULT);

   typedef logic [FLOOR_W_DEFAULT-1:0] floor_t;

endpackage

// File: rtl/elevator_call_latch_if.sv
// Signal bundle between the call buttons / controller feedback and the call latch.
interface elevator_call_latch_if
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS = NUM_FLOORS_DEFAULT
);
   localparam int FLOOR_W = floor_w(NUM_FLOORS);

   // Level semantics, no valid/ready: btn is raw and asynchronous, floor is the
   // controller's registered car position, req/any_req are registered levels
   // that stay high until the car sits at the requested floor.
   logic [NUM_FLOORS-1:0] btn;
   logic [FLOOR_W-1:0]    floor;
   logic [NUM_FLOORS-1:0] req;
   logic                  any_req;

   modport master (
      output btn,
      output floor,
      input  req,
      input  any_req
   );

   modport slave (
      input  btn,
      input  floor,
      output req,
      output any_req
   );

endinterface

// File: rtl/call_debouncer.sv
// One call button: 2-flop synchronizer, stable-count debouncer and a one-cycle
// pulse when a press (0->1) is accepted.
module call_debouncer
   import elevator_pkg::*;
#(
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic clk,
   input  logic reset,
   input  logic btn,
   output logic set
);

   localparam int               CNT_W   = debounce_cnt_w(DEBOUNCE_CYCLES);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic             s1;
   logic             s2;
   logic             db;
   logic [CNT_W-1:0] cnt;
   logic             differs;
   logic             accept;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         s1 <= 1'b0;
         s2 <= 1'b0;
      end else begin
         s1 <= btn;
         s2 <= s1;
      end
   end

   assign differs = (s2 != db);
   assign accept  = differs && (cnt == CNT_MAX);

   // Any sample agreeing with db restarts the count, so short glitches die out.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         db  <= 1'b0;
         cnt <= '0;
      end else if (!differs) begin
         cnt <= '0;
      end else if (accept) begin
         db  <= s2;
         cnt <= '0;
      end else begin
         cnt <= cnt + 1'b1;
      end
   end

   // Releases are debounced identically but never produce an event.
   assign set = accept && s2;

endmodule

// File: rtl/elevator_call_latch.sv
// Per-floor pending call latches: set by debounced presses, cleared when the
// car reports it is at that floor.
module elevator_call_latch
   import elevator_pkg::*;
#(
   parameter int NUM_FLOORS      = NUM_FLOORS_DEFAULT,
   parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
   input  logic                 clk,
   input  logic                 reset,
   elevator_call_latch_if.slave bus
);

   localparam int FLOOR_W = floor_w(NUM_FLOORS);

   logic [NUM_FLOORS-1:0] set;
   logic [NUM_FLOORS-1:0] clr;
   logic [NUM_FLOORS-1:0] req_q;
   logic [NUM_FLOORS-1:0] req_next;
   logic                  any_q;

   for (genvar i = 0; i < NUM_FLOORS; i++) begin : g_floor
      call_debouncer #(
         .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
      ) u_debounce (
         .clk  (clk),
         .reset(reset),
         .btn  (bus.btn[i]),
         .set  (set[i])
      );

      // Out-of-range floor codes match no index and so clear nothing.
      assign clr[i] = (bus.floor == FLOOR_W'(i));
   end

   // Clear wins over set: a press at the occupied floor is already served.
   always_comb begin
      req_next = req_q;
      req_next = (req_next | set) & ~clr;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         req_q <= '0;
         any_q <= 1'b0;
      end else begin
         req_q <= req_next;
         any_q <= |req_next;
      end
   end

   assign bus.req     = req_q;
   assign bus.any_req = any_q;

endmodule

// File: tb/tb_elevator_call_latch.sv
// Scenario bench for elevator_call_latch: expected {any_req, req} per edge are
// queued as stimulus is applied and compared as the clock advances.
module tb_elevator_call_latch;
   import elevator_pkg::*;

   localparam int NF = 2;
   localparam int DB = 4;

   logic clk;
   logic reset;

   int n_cmp = 0;
   int n_err = 0;

   logic [NF:0] exp_q[$];

   elevator_call_latch_if #(.NUM_FLOORS(NF)) bus ();

   elevator_call_latch #(
      .NUM_FLOORS     (NF),
      .DEBOUNCE_CYCLES(DB)
   ) dut (
      .clk  (clk),
      .reset(reset),
      .bus  (bus.slave)
   );

   // clock / reset
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
      $fatal(1);
   end

   // driver tasks (called at #1 after a rising edge)
   task automatic drive(input logic [NF-1:0] b, input floor_t f);
      bus.btn   = b;
      bus.floor = f;
   endtask

   task automatic apply_reset();
      reset = 1'b1;
      @(posedge clk);
      #1;
      reset = 1'b0;
   endtask

   task automatic push_n(input logic [NF:0] v, input int n);
      for (int k = 0; k < n; k++) exp_q.push_back(v);
   endtask

   // scenarios
   task automatic test_reset();
      logic [NF:0] obs;
      logic [NF:0] exp;
      drive('0, '0);
      reset = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      exp = exp_q.size() == 0 ? {(NF+1){1'b0}} : exp_q.pop_front();
      obs = {bus.any_req, bus.req};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL reset_state: got %b expected %b", obs, exp);
      end
      reset = 1'b0;
   endtask

   task automatic test_press();
      logic [NF:0] obs;
      logic [NF:0] exp;
      int cyc = 1;
      apply_reset();
      drive(2'b10, 1'b0);
      push_n(3'b000, 5);
      push_n(3'b110, 3);
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL press edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
      // releasing the button must not drop the pending call
      drive(2'b00, 1'b0);
      push_n(3'b110, 8);
      cyc = 1;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL release_hold edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_bounce();
      logic [NF:0] obs;
      logic [NF:0] exp;
      int cyc = 1;
      logic [NF-1:0] pattern[12] = '{2'b10, 2'b10, 2'b10, 2'b00, 2'b10, 2'b10,
                                     2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10};
      apply_reset();
      // final rise is sampled at edge 5, so the call appears at edge 10
      push_n(3'b000, 9);
      push_n(3'b110, 3);
      for (int k = 0; k < 12; k++) begin
         drive(pattern[k], 1'b0);
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL bounce edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_service();
      logic [NF:0] obs;
      logic [NF:0] exp;
      int cyc = 1;
      // continues from test_bounce: req[1] pending, btn[1] held, floor 0
      drive(2'b10, 1'b1);
      push_n(3'b000, 1);
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL service_clear edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
      // car leaves again with the button still held: no new press
      drive(2'b10, 1'b0);
      push_n(3'b000, 10);
      cyc = 1;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL service_held edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_clear_dominance();
      logic [NF:0] obs;
      logic [NF:0] exp;
      int cyc = 1;
      drive(2'b00, 1'b0);
      apply_reset();
      drive(2'b01, 1'b0);
      push_n(3'b000, 10);
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL clear_dominance edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_simultaneous();
      logic [NF:0] obs;
      logic [NF:0] exp;
      int cyc = 1;
      drive(2'b00, 1'b1);
      apply_reset();
      drive(2'b11, 1'b1);
      push_n(3'b000, 5);
      push_n(3'b101, 3);
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL simultaneous edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
   endtask

   task automatic test_reset_mid();
      logic [NF:0] obs;
      logic [NF:0] exp;
      int cyc = 1;
      drive(2'b00, 1'b0);
      apply_reset();
      drive(2'b10, 1'b0);
      push_n(3'b000, 5);
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_mid_pre edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
      // edge 6 would accept the press; reset lands just before it
      reset = 1'b1;
      @(posedge clk);
      #1;
      exp = 3'b000;
      obs = {bus.any_req, bus.req};
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL reset_mid_held: got %b expected %b", obs, exp);
      end
      reset = 1'b0;
      push_n(3'b000, 5);
      push_n(3'b110, 3);
      cyc = 1;
      while (exp_q.size() != 0) begin
         @(posedge clk);
         #1;
         exp = exp_q.pop_front();
         obs = {bus.any_req, bus.req};
         n_cmp++;
         if (obs !== exp) begin
            n_err++;
            $display("FAIL reset_mid_relatch edge %0d: got %b expected %b", cyc, obs, exp);
         end
         cyc++;
      end
   endtask

   initial begin
      reset = 1'b1;
      bus.btn = '0;
      bus.floor = '0;
      exp_q.push_back(3'b000);
      test_reset();
      @(posedge clk);
      #1;
      test_press();
      test_bounce();
      test_service();
      test_clear_dominance();
      test_simultaneous();
      test_reset_mid();
      n_cmp++;
      if (exp_q.size() != 0) begin
         n_err++;
         $display("FAIL queue_drain: got %0d left expected 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/elevator_call_latch.md
# elevator_call_latch

Upstream request stage for the elevator controller. Takes raw, asynchronous, bouncing floor call buttons and synchronizes and debounces each one. It latches every accepted press as a pending call and holds it until the car reports it is at that floor. The per-floor pending vector drives the controller's request inputs directly: `req[0]` feeds `req0`, `req[1]` feeds `req1`. The controller's `floor` output is fed back here to cancel served calls.

## Interface
Parameters:
- NUM_FLOORS, 2, number of floors and call buttons (>= 2)
- DEBOUNCE_CYCLES, 4, consecutive stable synchronized samples required to accept a level change (>= 2)
- FLOOR_W, max(1, clog2(NUM_FLOORS)), width of the floor feedback (derived, localparam)

Ports:
- clk  input  1  clock
- reset  input  1  asynchronous, active-high reset
- btn  input  NUM_FLOORS  raw call buttons, asynchronous, may bounce, 1 = pressed
- floor  input  FLOOR_W  current car floor from the elevator controller (registered there)
- req  output  NUM_FLOORS  pending call per floor, registered, to controller request inputs
- any_req  output  1  OR of req, registered

## Operation
- The per-button pipeline is: 2-flop synchronizer, then debouncer, then press detect, then pending latch.
- Synchronizer:
  - `s1 <= btn`, `s2 <= s1`.
  - Only `s2` is used downstream.
- Debouncer, per button:
  - State is the debounced level `db` and a counter `cnt` of width clog2(DEBOUNCE_CYCLES).
  - If `s2 == db`, then `cnt <= 0`.
  - Else if `cnt == DEBOUNCE_CYCLES-1`, then `db <= s2` and `cnt <= 0`.
  - Else `cnt <= cnt+1`.
  - Any sample that agrees with `db` restarts the count. A glitch shorter than DEBOUNCE_CYCLES synchronized cycles is therefore never accepted.
- Press detect: `set_i` is asserted in the cycle where the debouncer accepts a 0→1 change (`s2=1`, `db=0`, `cnt=DEBOUNCE_CYCLES-1`). Release (1→0) is debounced the same way but generates no event.
- Pending latch, per floor `i`:
  - `clr_i = (floor == i)`.
  - If `clr_i`, then `req[i] <= 0`.
  - Else if `set_i`, then `req[i] <= 1`.
  - Otherwise `req[i]` holds.
  - Clear dominates set: a press at the floor the car already occupies is discarded.
  - A held or repeated press while pending is idempotent.
- `floor` values >= NUM_FLOORS match no index and clear nothing.
- `any_req` is registered from the next-state value of `req`, so it is cycle-aligned with `req`.

## Timing
- Reset values: `s1`, `s2`, `db`, `cnt`, `req` and `any_req` are all 0.
- Press latency, with edge 1 being the first rising clock edge after `btn[i]` goes stably high:
  - `s2` is 1 after edge 2.
  - `req[i]` is 1 after edge 2+DEBOUNCE_CYCLES. With the default of 4, that is edge 6.
- Clear latency: `req[i]` falls at the first edge at which `floor == i` is sampled, one cycle after the controller's `floor` register changes.
- Simultaneous events:
  - Presses on different floors in the same cycle each latch independently.
  - A set and a clear on the same floor in the same cycle leave that floor cleared.
- Reset mid-operation:
  - All state clears immediately (asynchronous reset).
  - A button still held after reset deasserts is treated as a new press and re-latched 2+DEBOUNCE_CYCLES edges later.
- Release does not affect `req`. A call persists until it is served.

## Structure
- Shared package (`elevator_pkg`):
  - NUM_FLOORS default and the FLOOR_W derivation
  - the floor-index type shared with the elevator controller
- Sub-module `call_debouncer`:
  - one instance per button, generate loop
  - contains the synchronizer, counter, `db` and the `set` pulse output
  - parameter DEBOUNCE_CYCLES
- The top level holds only the pending latches, the clear decode and `any_req`.

## Test plan
- Reset, then hold `btn=2'b10` with `floor=0` → `req=2'b10` and `any_req=1` exactly after edge 6. No earlier change.
- Bounce: `btn[1]` pulses high for 3 cycles, low for 1 cycle, then high steadily, with `floor=0` → no `req` from the pulses; `req[1]=1` 6 edges after the final rise.
- Service: pending `req[1]=1`, then `floor` changes 0→1 → `req[1]=0` at the next edge, `any_req=0`. `btn` still held afterwards does not re-set the call.
- Clear dominance: `floor=0`, hold `btn[0]` → `req[0]` stays 0 throughout.
- Simultaneous: `floor=1`, press `btn=2'b11` together → `req=2'b01` after edge 6.
- Reset mid-press: assert `reset` on the cycle before the debouncer would accept a held press, then release → all outputs 0. `req` sets 6 edges after reset release while `btn` stays held.
